// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: target FSM states, the OV7670 write address and the
// ACK/NACK bit levels as seen on SDA.
package sccb_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StSub,
      StSubAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdataAck,
      StWait
   } sccb_state_e;

   localparam logic [7:0] SCCB_WR_ADDR_OV7670 = 8'h42;
   localparam logic       SCCB_ACK            = 1'b0;
   localparam logic       SCCB_NACK           = 1'b1;

   // Address match ignores the R/W bit.
   function automatic logic sccb_addr_match(input logic [7:0] rx_byte,
                                            input logic [7:0] own_addr);
      return rx_byte[7:1] == own_addr[7:1];
   endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises SCL/SDA into the system clock domain and produces single-cycle
// edge pulses plus START/STOP conditions.
module sccb_line_sync #(
   parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_hist;
   logic                   r_sda_hist;
   logic                   w_scl;
   logic                   w_sda;
   logic                   w_sda_rise;
   logic                   w_sda_fall;

   // Synchroniser chains plus one history flop; reset to the idle-high bus level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_hist <= w_scl;
         r_sda_hist <= w_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_sda_rise = w_sda & ~r_sda_hist;
   assign w_sda_fall = ~w_sda & r_sda_hist;

   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_hist;
   assign o_scl_fall = ~w_scl & r_scl_hist;
   assign o_start    = w_sda_fall & w_scl;
   assign o_stop     = w_sda_rise & w_scl;

endmodule

// File: rtl/sccb_slave.sv
// SCCB/I2C target: acknowledges its 7-bit address, turns write bytes into
// register-file write strobes and serves reads from an external register file.
module sccb_slave
   import sccb_pkg::*;
#(
   parameter logic [7:0]  SLAVE_ADDR  = 8'h42,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       iCLK,
   input  logic       rst,
   input  logic       I2C_SCLK,
   input  logic       I2C_SDAT_i,
   output logic       I2C_SDAT_oe,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

   logic        w_sda;
   logic        w_scl_rise;
   logic        w_scl_fall;
   logic        w_start;
   logic        w_stop;
   logic [7:0]  w_rx_byte;

   sccb_state_e r_state;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_ptr;
   logic [7:0]  r_rd_byte;
   logic        r_rw;
   logic        r_rd_load;  // next SCL fall latches rd_data for a follow-on read byte
   logic        r_oe;
   logic        r_wr_en;
   logic [7:0]  r_wr_addr;
   logic [7:0]  r_wr_data;
   logic        r_busy;

   sccb_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .i_clk      (iCLK),
      .i_rst      (rst),
      .i_scl      (I2C_SCLK),
      .i_sda      (I2C_SDAT_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   // Byte as it will look once the bit sampled on this SCL rise is shifted in.
   assign w_rx_byte = {r_shift[6:0], w_sda};

   // Protocol FSM; all outputs are registered. STOP/START override any SCL edge.
   always_ff @(posedge iCLK) begin
      if (rst) begin
         r_state   <= StIdle;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_ptr     <= 8'h00;
         r_rd_byte <= 8'h00;
         r_rw      <= 1'b0;
         r_rd_load <= 1'b0;
         r_oe      <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= 8'h00;
         r_wr_data <= 8'h00;
         r_busy    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_stop) begin
            r_state   <= StIdle;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_rd_load <= 1'b0;
         end else if (w_start) begin
            r_state   <= StAddr;
            r_oe      <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= 3'd0;
            r_rd_load <= 1'b0;
         end else begin
            unique case (r_state)
               StAddr: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_rx_byte;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        if (sccb_addr_match(w_rx_byte, SLAVE_ADDR)) begin
                           r_rw    <= w_sda;
                           r_state <= StAddrAck;
                        end else begin
                           r_state <= StWait;
                        end
                     end
                  end
               end
               // Ack states: first SCL fall starts driving ACK, second one releases it.
               StAddrAck: begin
                  if (w_scl_fall) begin
                     if (!r_oe) begin
                        r_oe <= 1'b1;
                     end else begin
                        r_bit_cnt <= 3'd0;
                        if (r_rw) begin
                           // First read bit goes out on the release edge itself.
                           r_state   <= StRdata;
                           r_rd_byte <= rd_data;
                           r_oe      <= ~rd_data[7];
                        end else begin
                           r_state <= StSub;
                           r_oe    <= 1'b0;
                        end
                     end
                  end
               end
               StSub: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_rx_byte;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_ptr   <= w_rx_byte;
                        r_state <= StSubAck;
                     end
                  end
               end
               StSubAck: begin
                  if (w_scl_fall) begin
                     if (!r_oe) begin
                        r_oe <= 1'b1;
                     end else begin
                        r_oe      <= 1'b0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= StWdata;
                     end
                  end
               end
               StWdata: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_rx_byte;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= w_rx_byte;
                        r_state   <= StWdataAck;
                     end
                  end
               end
               StWdataAck: begin
                  if (w_scl_fall) begin
                     if (!r_oe) begin
                        r_oe <= 1'b1;
                     end else begin
                        r_oe      <= 1'b0;
                        r_bit_cnt <= 3'd0;
                        r_ptr     <= r_ptr + 8'd1;
                        r_state   <= StWdata;
                     end
                  end
               end
               StRdata: begin
                  if (w_scl_fall) begin
                     if (r_rd_load) begin
                        r_rd_load <= 1'b0;
                        r_rd_byte <= rd_data;
                        r_oe      <= ~rd_data[7];
                        r_bit_cnt <= 3'd0;
                     end else if (r_bit_cnt == 3'd7) begin
                        r_oe    <= 1'b0;
                        r_state <= StRdataAck;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_oe      <= ~r_rd_byte[3'd6 - r_bit_cnt];
                     end
                  end
               end
               StRdataAck: begin
                  if (w_scl_rise) begin
                     if (w_sda == SCCB_ACK) begin
                        r_ptr     <= r_ptr + 8'd1;
                        r_rd_load <= 1'b1;
                        r_state   <= StRdata;
                     end else begin
                        r_state <= StWait;
                     end
                  end
               end
               StIdle, StWait: begin
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign I2C_SDAT_oe = r_oe;
   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign rd_addr     = r_ptr;
   assign busy        = r_busy;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: a bus-master model drives SCL/SDA; expected register
// writes go into a scoreboard queue checked by a monitor on wr_en.
module tb_sccb_slave;
   import sccb_pkg::*;

   logic       iCLK = 1'b0;
   logic       rst  = 1'b1;
   logic       scl  = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       oe;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         oe_cycles = 0;
   logic [15:0] exp_wr[$];

   always #5 iCLK = ~iCLK;

   assign sda_bus = sda_m & ~oe;

   sccb_slave #(
      .SLAVE_ADDR  (SCCB_WR_ADDR_OV7670),
      .SYNC_STAGES (2)
   ) dut (
      .iCLK        (iCLK),
      .rst         (rst),
      .I2C_SCLK    (scl),
      .I2C_SDAT_i  (sda_bus),
      .I2C_SDAT_oe (oe),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy)
   );

   // External register file model: one-cycle read latency.
   function automatic logic [7:0] reg_model(input logic [7:0] a);
      return (a == 8'h0A) ? 8'h76 : (a ^ 8'hA5);
   endfunction

   always @(posedge iCLK) rd_data <= reg_model(rd_addr);

   always @(posedge iCLK) if (oe) oe_cycles <= oe_cycles + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic send_bit(input logic b);
      clk_n(4); sda_m = b; clk_n(6); scl = 1'b1; clk_n(10); scl = 1'b0;
   endtask

   task automatic recv_bit(output logic b);
      clk_n(4); sda_m = 1'b1; clk_n(6); scl = 1'b1; clk_n(5); b = sda_bus; clk_n(5); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
      for (int i = 7; i >= 0; i--) recv_bit(d[i]);
      send_bit(ack_bit);
   endtask

   task automatic start_c();
      clk_n(4); sda_m = 1'b1; clk_n(6); scl = 1'b1; clk_n(10); sda_m = 1'b0; clk_n(10); scl = 1'b0;
   endtask

   task automatic stop_c();
      clk_n(4); sda_m = 1'b0; clk_n(6); scl = 1'b1; clk_n(10); sda_m = 1'b1; clk_n(10);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic [7:0] rb;
      int         oe_base;
      bit         seen;

      // Scoreboard monitor: every wr_en must match the oldest expected write.
      fork
         forever begin
            @(negedge iCLK);
            if (wr_en) begin
               if (exp_wr.size() == 0) begin
                  chk("unexpected_wr", {16'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
               end else begin
                  chk("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_wr.pop_front()});
               end
            end
         end
      join_none

      clk_n(3);
      rst = 1'b0;
      clk_n(2);
      chk("rst_oe", oe, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", busy, 0);

      // Single write 0x42,0x12,0x80.
      start_c();
      chk("w1_busy", busy, 1);
      exp_wr.push_back(16'h1280);
      send_byte(8'h42, ack); chk("w1_ack_addr", ack, 0);
      send_byte(8'h12, ack); chk("w1_ack_sub", ack, 0);
      send_byte(8'h80, ack); chk("w1_ack_data", ack, 0);
      stop_c();
      chk("w1_busy_after_stop", busy, 0);
      chk("w1_wr_addr_held", wr_addr, 8'h12);

      // Foreign address: no ACK, no write, busy until STOP.
      oe_base = oe_cycles;
      start_c();
      send_byte(8'h60, ack); chk("foreign_ack", ack, 1);
      send_byte(8'h12, ack); chk("foreign_ack2", ack, 1);
      chk("foreign_busy", busy, 1);
      chk("foreign_no_oe", oe_cycles - oe_base, 0);
      stop_c();
      chk("foreign_busy_after_stop", busy, 0);

      // Burst with pointer wrap.
      exp_wr.push_back(16'hFE11);
      exp_wr.push_back(16'hFF22);
      exp_wr.push_back(16'h0033);
      start_c();
      send_byte(8'h42, ack); chk("burst_ack_addr", ack, 0);
      send_byte(8'hFE, ack); chk("burst_ack_sub", ack, 0);
      send_byte(8'h11, ack); chk("burst_ack_d0", ack, 0);
      send_byte(8'h22, ack); chk("burst_ack_d1", ack, 0);
      send_byte(8'h33, ack); chk("burst_ack_d2", ack, 0);
      stop_c();

      // Set pointer, repeated START, read two bytes (ACK then NACK).
      start_c();
      send_byte(8'h42, ack); chk("rd_ack_addr", ack, 0);
      send_byte(8'h0A, ack); chk("rd_ack_sub", ack, 0);
      start_c();
      send_byte(8'h43, ack); chk("rd_ack_raddr", ack, 0);
      recv_byte(rb, SCCB_ACK);  chk("rd_byte0", rb, 8'h76);
      recv_byte(rb, SCCB_NACK); chk("rd_byte1", rb, 8'hAE);
      chk("rd_oe_after_nack", oe, 0);
      stop_c();
      chk("rd_bus_released", sda_bus, 1);
      chk("rd_busy_after_stop", busy, 0);

      // STOP after 4 data bits: partial byte discarded.
      start_c();
      send_byte(8'h42, ack);
      send_byte(8'h20, ack);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      stop_c();
      chk("partial_state_idle", dut.r_state == StIdle, 1);
      chk("partial_oe", oe, 0);
      chk("partial_busy", busy, 0);

      // Reset in the middle of an address ACK.
      start_c();
      for (int i = 7; i >= 0; i--) send_bit(SCCB_WR_ADDR_OV7670[i]);
      clk_n(2);
      sda_m = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         clk_n(1);
         if (oe) seen = 1'b1;
      end
      chk("mid_ack_oe_seen", seen, 1);
      rst = 1'b1;
      clk_n(1);
      rst = 1'b0;
      chk("rst2_oe", oe, 0);
      chk("rst2_wr_en", wr_en, 0);
      chk("rst2_wr_addr", wr_addr, 0);
      chk("rst2_wr_data", wr_data, 0);
      chk("rst2_rd_addr", rd_addr, 0);
      chk("rst2_busy", busy, 0);
      exp_wr.push_back(16'h3355);
      start_c();
      send_byte(8'h42, ack); chk("post_rst_ack_addr", ack, 0);
      send_byte(8'h33, ack); chk("post_rst_ack_sub", ack, 0);
      send_byte(8'h55, ack); chk("post_rst_ack_data", ack, 0);
      stop_c();

      clk_n(20);
      chk("wr_queue_drained", exp_wr.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
